// File: rtl/mdu_if.sv
// Operand, HI/LO write and result bundle between the execute stage and the mdu.
interface mdu_if #(parameter int WIDTH = 32);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             hi_we;
   logic             lo_we;
   logic [WIDTH-1:0] wdata;
   logic             busy;
   logic             done;
   logic             dz;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport slave (
      input  start, op, a, b, hi_we, lo_we, wdata,
      output busy, done, dz, hi, lo
   );

   modport master (
      output start, op, a, b, hi_we, lo_we, wdata,
      input  busy, done, dz, hi, lo
   );
endinterface

// File: rtl/mdu.sv
// Iterative MIPS multiply/divide unit: shift-add multiply, restoring divide,
// sign fix-up in a final cycle, plus the architectural HI/LO registers.
module mdu #(
   parameter int WIDTH = 32
) (
   input  logic clk,
   input  logic rst,
   mdu_if.slave bus
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP} state_t;

   state_t           r_state, w_next;
   logic [CW-1:0]    r_cnt;
   logic             r_div;
   logic             r_neg_q;
   logic             r_neg_r;
   logic             r_dzp;
   logic             r_dz;
   logic             r_done;
   logic [WIDTH-1:0] r_x;
   logic [WIDTH:0]   r_ph;
   logic [WIDTH-1:0] r_pl;
   logic [WIDTH-1:0] r_hi;
   logic [WIDTH-1:0] r_lo;

   // Operand decode at the start edge. A zero divisor forces the unsigned
   // view so the divider naturally yields quotient all-ones, remainder a.
   logic             w_div, w_bz, w_sgn, w_a_neg, w_b_neg;
   logic [WIDTH-1:0] w_a_mag, w_b_mag;

   assign w_div   = bus.op[1];
   assign w_bz    = w_div & (bus.b == '0);
   assign w_sgn   = ~bus.op[0] & ~w_bz;
   assign w_a_neg = w_sgn & bus.a[WIDTH-1];
   assign w_b_neg = w_sgn & bus.b[WIDTH-1];
   assign w_a_mag = w_a_neg ? -bus.a : bus.a;
   assign w_b_mag = w_b_neg ? -bus.b : bus.b;

   logic [WIDTH:0]   w_madd, w_msum, w_shl, w_diff;

   assign w_madd = {1'b0, r_ph[WIDTH-1:0]} + {1'b0, r_x};
   assign w_msum = r_pl[0] ? w_madd : {1'b0, r_ph[WIDTH-1:0]};
   assign w_shl  = {r_ph[WIDTH-1:0], r_pl[WIDTH-1]};
   assign w_diff = w_shl - {1'b0, r_x};

   logic [2*WIDTH-1:0] w_prod, w_prod_s;
   logic [WIDTH-1:0]   w_quo, w_rem;

   assign w_prod   = {r_ph[WIDTH-1:0], r_pl};
   assign w_prod_s = r_neg_q ? -w_prod : w_prod;
   assign w_quo    = r_neg_q ? -r_pl : r_pl;
   assign w_rem    = r_neg_r ? -r_ph[WIDTH-1:0] : r_ph[WIDTH-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_next = S_CALC;
         S_CALC:  if (r_cnt == CW'(WIDTH-1)) w_next = S_FIXUP;
         S_FIXUP: w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt   <= '0;
         r_div   <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dzp   <= 1'b0;
         r_dz    <= 1'b0;
         r_done  <= 1'b0;
         r_x     <= '0;
         r_ph    <= '0;
         r_pl    <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.hi_we) r_hi <= bus.wdata;
               if (bus.lo_we) r_lo <= bus.wdata;
               if (bus.start) begin
                  r_div   <= w_div;
                  r_neg_q <= w_a_neg ^ w_b_neg;
                  r_neg_r <= w_div & w_a_neg;
                  r_dzp   <= w_bz;
                  r_dz    <= 1'b0;
                  r_cnt   <= '0;
                  r_ph    <= '0;
                  // Multiply: x = multiplicand, P_lo = multiplier.
                  // Divide:   x = divisor,      P_lo = dividend.
                  r_x     <= w_div ? w_b_mag : w_a_mag;
                  r_pl    <= w_div ? w_a_mag : w_b_mag;
               end
            end
            S_CALC: begin
               r_cnt <= r_cnt + CW'(1);
               if (!r_div) begin
                  r_ph <= {1'b0, w_msum[WIDTH:1]};
                  r_pl <= {w_msum[0], r_pl[WIDTH-1:1]};
               end else if (!w_diff[WIDTH]) begin
                  r_ph <= w_diff;
                  r_pl <= {r_pl[WIDTH-2:0], 1'b1};
               end else begin
                  r_ph <= w_shl;
                  r_pl <= {r_pl[WIDTH-2:0], 1'b0};
               end
            end
            S_FIXUP: begin
               r_done <= 1'b1;
               r_dz   <= r_dzp;
               if (r_div) begin
                  r_hi <= w_rem;
                  r_lo <= w_quo;
               end else begin
                  r_hi <= w_prod_s[2*WIDTH-1:WIDTH];
                  r_lo <= w_prod_s[WIDTH-1:0];
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy = (r_state != S_IDLE);
   assign bus.done = r_done;
   assign bus.dz   = r_dz;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table of mult/div results plus hand-written
// sequences for HI/LO writes, ignored requests while busy and mid-op reset.
module tb_mdu;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mdu_if #(.WIDTH(32)) bus ();
   mdu #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   int errs = 0;
   int checks = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz,
                         input bit inj, input string nm);
      int n, nb, both;
      @(negedge clk);
      bus.op = op; bus.a = a; bus.b = b; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      chk({nm, ".dz_at_start"}, {31'd0, bus.dz}, 32'd0);
      n = 0; both = 0;
      nb = bus.busy ? 1 : 0;
      while (!bus.done && n < 100) begin
         if (inj && n == 5) begin
            bus.hi_we = 1'b1; bus.wdata = 32'h11111111;
            bus.start = 1'b1; bus.op = 2'b00; bus.a = 32'd5; bus.b = 32'd5;
         end
         @(posedge clk); #1;
         n++;
         if (bus.busy) nb++;
         if (bus.busy && bus.done) both++;
         if (inj && n == 6) begin
            bus.hi_we = 1'b0; bus.start = 1'b0;
         end
      end
      chk({nm, ".latency"}, n, 33);
      chk({nm, ".busy_cycles"}, nb, 33);
      chk({nm, ".busy_and_done"}, both, 0);
      chk({nm, ".hi"}, bus.hi, eh);
      chk({nm, ".lo"}, bus.lo, el);
      chk({nm, ".dz"}, {31'd0, bus.dz}, {31'd0, edz});
      @(posedge clk); #1;
      chk({nm, ".after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
   endtask

   initial begin
      vecs[0]  = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0};
      vecs[1]  = '{2'b01, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 1'b0};
      vecs[2]  = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
      vecs[3]  = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
      vecs[4]  = '{2'b11, 32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 1'b0};
      vecs[5]  = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
      vecs[6]  = '{2'b11, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1};
      vecs[7]  = '{2'b00, 32'h00000002, 32'h00000003, 32'h00000000, 32'h00000006, 1'b0};
      vecs[8]  = '{2'b00, 32'hFFFFFFF9, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0};
      vecs[9]  = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
      vecs[10] = '{2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
      vecs[11] = '{2'b10, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1};
      vecs[12] = '{2'b01, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};

      bus.start = 1'b0; bus.op = 2'b00; bus.a = '0; bus.b = '0;
      bus.hi_we = 1'b0; bus.lo_we = 1'b0; bus.wdata = '0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset.hi", bus.hi, 32'd0);
      chk("reset.lo", bus.lo, 32'd0);
      chk("reset.flags", {29'd0, bus.busy, bus.done, bus.dz}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 13; i++)
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].dz,
                1'b0, $sformatf("vec%0d", i));

      // mthi then mtlo in IDLE
      @(negedge clk);
      bus.hi_we = 1'b1; bus.wdata = 32'hAAAA5555;
      @(posedge clk); #1;
      bus.hi_we = 1'b0;
      chk("mthi.hi", bus.hi, 32'hAAAA5555);
      chk("mthi.lo_kept", bus.lo, 32'h00000000);
      @(negedge clk);
      bus.lo_we = 1'b1; bus.wdata = 32'h0000BEEF;
      @(posedge clk); #1;
      bus.lo_we = 1'b0;
      chk("mtlo.lo", bus.lo, 32'h0000BEEF);
      chk("mtlo.hi_kept", bus.hi, 32'hAAAA5555);

      // write and second start while dividing are both ignored
      run_op(2'b11, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0, 1'b1, "busy_ignore");

      // reset in the middle of a multiply
      @(negedge clk);
      bus.op = 2'b00; bus.a = 32'd3; bus.b = 32'd5; bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk("midop.busy_before", {31'd0, bus.busy}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst.hi", bus.hi, 32'd0);
      chk("midrst.lo", bus.lo, 32'd0);
      chk("midrst.flags", {29'd0, bus.busy, bus.done, bus.dz}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      run_op(2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b0, "after_rst");

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/mdu.md
# mdu

Iterative multiply/divide unit with architectural HI/LO registers for the MIPS execute stage. It sits beside the ALU and consumes the same decoded operands (rs value, rt value, funct-derived op). It executes mult, multu, div and divu over multiple cycles, and serves mfhi/mflo reads and mthi/mtlo writes. Hazard logic stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each `WIDTH` bits wide.
- `clk`  in  1: single clock; all state changes on its rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `start`  in  1: request an operation; sampled only in IDLE.
- `op`  in  2: 00 mult, 01 multu, 10 div, 11 divu.
- `a`  in  32: rs value (multiplicand or dividend).
- `b`  in  32: rt value (multiplier or divisor).
- `hi_we`  in  1: mthi write enable.
- `lo_we`  in  1: mtlo write enable.
- `wdata`  in  32: mthi/mtlo data.
- `busy`  out  1: operation in flight.
- `done`  out  1: one-cycle pulse when HI/LO hold a new result.
- `dz`  out  1: last div/divu had divisor 0. Held until the next accepted start.
- `hi`  out  32: HI register.
- `lo`  out  32: LO register.

## Operation
- States: IDLE, CALC, FIXUP.
- IDLE → CALC on `start`. At that edge the unit:
  - latches `op`;
  - takes magnitudes of `a` and `b` (signed ops only);
  - records the result signs;
  - clears `dz`;
  - sets the iteration counter to 0.
- CALC runs exactly 32 iterations, one per cycle, counter 0..31. CALC → FIXUP after iteration 31.
- Multiply uses radix-2 shift-add on the 64-bit accumulator {P_hi, P_lo}. Each iteration: if the multiplier LSB is 1, add the multiplicand to the upper half with carry-out kept, then shift the accumulator right 1.
- Divide uses restoring division with a 33-bit partial remainder. Each iteration: shift in the next dividend bit, trial-subtract the divisor; if the result is non-negative, keep it and shift quotient bit 1, otherwise restore and shift 0.
- FIXUP writes the results to HI/LO and returns to IDLE:
  - mult: negate the 64-bit product if the operand signs differ.
  - div: negate the quotient if the operand signs differ; the remainder takes the sign of the dividend (truncation toward zero).
  - Multiply: HI = product[63:32], LO = product[31:0]. Divide: LO = quotient, HI = remainder.
- Signed-overflow case: div 0x80000000 / 0xFFFFFFFF gives LO = 0x80000000, HI = 0. No trap.
- Divide by zero (div or divu with b = 0):
  - latency is unchanged;
  - HI = a (original, unsigned view), LO = 0xFFFFFFFF;
  - `dz` = 1, set in FIXUP.
- The multiply sign rule applies only to mult and div. multu and divu treat operands as unsigned.
- mthi/mtlo:
  - In IDLE, `hi_we`/`lo_we` write `wdata` to HI/LO at the edge. Both may be asserted in the same cycle.
  - While `busy`, writes are ignored.
  - If `start` and a write occur together in IDLE, the write takes effect and is later overwritten by FIXUP.
- `start` while busy is ignored; no queueing.
- `hi`/`lo` outputs reflect the registers directly. Results are never visible before FIXUP.

## Timing
- Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `dz` = 0, state IDLE, counter 0.
- Reset mid-operation aborts immediately and returns to these values.
- Edge numbering: `start` is accepted at edge E0.
  - E1..E32: CALC iterations.
  - E33: FIXUP edge; HI/LO/`dz` are updated and the state returns to IDLE.
- `busy` is high in the cycles after E0 through E32 inclusive (33 cycles), and low after E33.
- `done` is high only in the cycle after E33. Latency from the start cycle to `done`: 34 cycles.
- A new `start` may be accepted at E34, during the `done` cycle. Back-to-back issue period: 34 cycles.
- `busy` and `done` are never high together.

## Test plan
- mult a=0xFFFFFFFE, b=0x00000003 → hi=0xFFFFFFFF, lo=0xFFFFFFFA; `done` in cycle 34; `busy` high for exactly 33 cycles.
- multu a=0xFFFFFFFE, b=0x00000003 → hi=0x00000002, lo=0xFFFFFFFA. Then multu 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- div a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then divu a=7, b=2 → lo=3, hi=1. Then div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- divu a=0x12345678, b=0 → hi=0x12345678, lo=0xFFFFFFFF, dz=1 after E33. Then a following mult 2×3 → dz=0 from its start edge; hi=0, lo=6.
- mthi 0xAAAA5555 and mtlo 0x0000BEEF in IDLE → hi/lo update next edge. During a divide, hi_we with 0x11111111 and a second `start` → both ignored; the divide result is unchanged.
- Assert `rst` at cycle 10 of a mult → all outputs 0 immediately. A new div 100/7 started after reset release → lo=14, hi=2 in cycle 34.
